l2_tag_writer: RTL
==================

// Module: l2_tag_writer
// PURPOSE
//  Write side of the L2 tag/state arrays; pairs with the L2 lookup logic. Buffers tag/state
//  updates from the L2 FSM (fill, eviction, state change) in a small FIFO and drains them to the
//  array write port in cycles the lookup is not reading. Flags pending same-set updates
//  (hazard) so a lookup never uses stale tags.
// PARAMETERS
//  WAYS       8   ways per set; WAY_BITS = $clog2(WAYS)
//  SET_BITS   9   set index width
//  TAG_BITS   15  tag width
//  STATE_BITS 3   coherence state width (INVALID = 0)
//  DEPTH      4   update FIFO entries, power of two >= 2
// PORTS
//  clk         in  1           clock
//  rst         in  1           async reset, active-low
//  upd_valid   in  1           update request valid
//  upd_ready   out 1           FIFO can accept (= !full)
//  upd_set     in  SET_BITS    target set
//  upd_way     in  WAY_BITS    target way
//  upd_tag     in  TAG_BITS    new tag
//  upd_state   in  STATE_BITS  new state
//  upd_mask    in  2           [0] write tag, [1] write state
//  arr_busy    in  1           lookup owns the array port this cycle
//  wr_en       out 1           array write strobe (registered)
//  wr_set/wr_way/wr_tag/wr_state/wr_mask  out  as upd_*; registered write fields
//  chk_set     in  SET_BITS    set being looked up
//  chk_hazard  out 1           comb: a FIFO entry or live write targets chk_set
//  pending_cnt out $clog2(DEPTH+1)  FIFO occupancy
//  drained     out 1           FIFO empty and wr_en low
// BEHAVIOUR
//  - Reset: FIFO emptied, wr_en=0, wr_* = 0, pending_cnt=0, drained=1, upd_ready=1.
//    Reset mid-operation discards all pending updates; no write issued after rst falls.
//  - Accept on upd_valid & upd_ready. upd_mask==0: accepted (handshake completes), not enqueued.
//  - Full: upd_ready=0 even if a pop occurs the same cycle (no push-through when full).
//  - Drain, each posedge: if FIFO non-empty & !arr_busy -> wr_en<=1, wr_*<=head fields, pop;
//    else wr_en<=0. wr_en is one cycle per entry; back-to-back drains allowed.
//  - Entry pushed into empty FIFO becomes eligible the next cycle (min latency accept->wr_en: 2 edges).
//  - Strict FIFO order; no coalescing; two updates to same set/way both written, in order.
//  - Simultaneous push and pop: occupancy unchanged; pointers wrap modulo DEPTH.
//  - chk_hazard = OR over valid entries (set==chk_set) OR (wr_en & wr_set==chk_set); pure comb,
//    includes an entry accepted this cycle only from the next cycle on.
//  - Masked fields: wr_tag/wr_state carry the entry value; array honours wr_mask.
// CONFIGURATION
//  L2_WR_BYPASS_EN defined: adds in chk_way[WAY_BITS]; outs fwd_tag_vld, fwd_tag, fwd_state_vld,
//   fwd_state. Comb: for each field, value from YOUNGEST pending source (FIFO entries, then live
//   write as oldest) matching chk_set & chk_way with that mask bit set; vld=0 if none.
//   chk_hazard still produced.
//  Not defined: those ports absent; stall-on-chk_hazard is the only protection.
// STRUCTURE
//  Shared package/headers: l2_wr_req_t struct (set, way, tag, state, mask) in cache_types;
//  L2_WR_MASK_TAG=2'b01, L2_WR_MASK_STATE=2'b10 in cache_consts.
//  Sub-module l2_wr_fifo: DEPTH-entry l2_wr_req_t FIFO exposing all entries + valid bits for
//  hazard/forward compare; top holds drain register and compare logic.
// TESTING
//  1. Reset mid-drain: 3 entries queued, pulse rst low -> wr_en=0, pending_cnt=0, drained=1.
//  2. One update set=5 way=2 tag=0x1A3 mask=3, arr_busy=0 -> wr_en 2 edges later, fields exact.
//  3. Fill 4 entries with arr_busy=1 -> upd_ready=0; drop arr_busy -> 4 wr_en cycles in order,
//     upd_ready=1 after first pop.
//  4. Entry set=7 pending, chk_set=7 -> chk_hazard=1; chk_set=8 -> 0; hazard holds during wr_en.
//  5. mask=0 request -> accepted, pending_cnt unchanged, no wr_en.
//  6. BYPASS_EN: set 3/way1 tag=0x10 mask=1 then state=2 mask=2 -> fwd_tag=0x10, fwd_state=2, both vld.

Source files
------------

// File: rtl/l2_tag_writer_pkg.sv
// Shared types and constants for the L2 tag/state array write path.
package l2_tag_writer_pkg;

  localparam int unsigned WAYS       = 8;
  localparam int unsigned WAY_BITS   = $clog2(WAYS);
  localparam int unsigned SET_BITS   = 9;
  localparam int unsigned TAG_BITS   = 15;
  localparam int unsigned STATE_BITS = 3;
  localparam int unsigned MASK_BITS  = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PTR_BITS   = $clog2(DEPTH);
  localparam int unsigned CNT_BITS   = $clog2(DEPTH + 1);

  localparam logic [MASK_BITS-1:0] L2_WR_MASK_TAG   = 2'b01;
  localparam logic [MASK_BITS-1:0] L2_WR_MASK_STATE = 2'b10;

  typedef struct packed {
    logic [SET_BITS-1:0]   set;
    logic [WAY_BITS-1:0]   way;
    logic [TAG_BITS-1:0]   tag;
    logic [STATE_BITS-1:0] state;
    logic [MASK_BITS-1:0]  mask;
  } l2_wr_req_t;

  // DEPTH is a power of two, so the increment wraps naturally.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return p + PTR_BITS'(1);
  endfunction

endpackage

// File: rtl/l2_tag_writer_wr_fifo.sv
// Update FIFO for the L2 tag writer. Exposes every slot plus its valid bit so
// the top level can compare pending updates against the lookup set.
module l2_tag_writer_wr_fifo
  import l2_tag_writer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  l2_wr_req_t               push_req_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [CNT_BITS-1:0]      count_o,
  output l2_wr_req_t               head_o,
  output logic [PTR_BITS-1:0]      head_ptr_o,
  output l2_wr_req_t [DEPTH-1:0]   entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  l2_wr_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic                   full_c;
  logic                   empty_c;
  logic                   push_ok_c;
  logic                   pop_ok_c;

  assign full_c    = (count_q == CNT_BITS'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign push_ok_c = push_i & ~full_c;
  assign pop_ok_c  = pop_i & ~empty_c;

  // Next-state: slot write/clear, pointer advance and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q]   = push_req_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop_ok_c) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o     = full_c;
  assign empty_o    = empty_c;
  assign count_o    = count_q;
  assign head_o     = mem_q[rd_ptr_q];
  assign head_ptr_o = rd_ptr_q;
  assign entries_o  = mem_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/l2_tag_writer.sv
// L2 tag/state array write side: buffers updates from the L2 FSM and drains
// them to the array write port whenever the lookup is not using it. Flags
// pending same-set updates so a lookup never consumes stale tags.
// Optional feature macro: L2_WR_BYPASS_EN (per-field forwarding of the
// youngest pending tag/state for chk_set/chk_way).
module l2_tag_writer
  import l2_tag_writer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   upd_valid_i,
  output logic                   upd_ready_o,
  input  logic [SET_BITS-1:0]    upd_set_i,
  input  logic [WAY_BITS-1:0]    upd_way_i,
  input  logic [TAG_BITS-1:0]    upd_tag_i,
  input  logic [STATE_BITS-1:0]  upd_state_i,
  input  logic [MASK_BITS-1:0]   upd_mask_i,
  input  logic                   arr_busy_i,
  output logic                   wr_en_o,
  output logic [SET_BITS-1:0]    wr_set_o,
  output logic [WAY_BITS-1:0]    wr_way_o,
  output logic [TAG_BITS-1:0]    wr_tag_o,
  output logic [STATE_BITS-1:0]  wr_state_o,
  output logic [MASK_BITS-1:0]   wr_mask_o,
  input  logic [SET_BITS-1:0]    chk_set_i,
`ifdef L2_WR_BYPASS_EN
  input  logic [WAY_BITS-1:0]    chk_way_i,
  output logic                   fwd_tag_vld_o,
  output logic [TAG_BITS-1:0]    fwd_tag_o,
  output logic                   fwd_state_vld_o,
  output logic [STATE_BITS-1:0]  fwd_state_o,
`endif
  output logic                   chk_hazard_o,
  output logic [CNT_BITS-1:0]    pending_cnt_o,
  output logic                   drained_o
);

  l2_wr_req_t             push_req_c;
  l2_wr_req_t             head_c;
  l2_wr_req_t [DEPTH-1:0] entries_c;
  logic [DEPTH-1:0]       valid_c;
  logic [PTR_BITS-1:0]    head_ptr_c;
  logic [CNT_BITS-1:0]    count_c;
  logic                   full_c;
  logic                   empty_c;
  logic                   push_c;
  logic                   pop_c;

  l2_wr_req_t             wr_req_q, wr_req_d;
  logic                   wr_en_q, wr_en_d;

  assign push_req_c = '{set: upd_set_i, way: upd_way_i, tag: upd_tag_i,
                        state: upd_state_i, mask: upd_mask_i};

  // Mask-zero requests complete the handshake but carry nothing to write.
  assign push_c = upd_valid_i & ~full_c & (upd_mask_i != '0);
  assign pop_c  = ~empty_c & ~arr_busy_i;

  l2_tag_writer_wr_fifo u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_c),
    .push_req_i (push_req_c),
    .pop_i      (pop_c),
    .full_o     (full_c),
    .empty_o    (empty_c),
    .count_o    (count_c),
    .head_o     (head_c),
    .head_ptr_o (head_ptr_c),
    .entries_o  (entries_c),
    .valid_o    (valid_c)
  );

  // Drain next-state: one write strobe per popped entry; fields hold otherwise.
  always_comb begin
    wr_en_d  = pop_c;
    wr_req_d = wr_req_q;
    if (pop_c) begin
      wr_req_d = head_c;
    end
  end

  // Drain register driving the array write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q  <= 1'b0;
      wr_req_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wr_req_q <= wr_req_d;
    end
  end

  // Hazard: any queued entry or the live write targets the set being looked up.
  always_comb begin
    chk_hazard_o = wr_en_q & (wr_req_q.set == chk_set_i);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_c[i] && (entries_c[i].set == chk_set_i)) begin
        chk_hazard_o = 1'b1;
      end
    end
  end

`ifdef L2_WR_BYPASS_EN
  logic [PTR_BITS-1:0] fwd_idx_c;

  // Forwarding: walk oldest (live write) to youngest entry, later matches win.
  always_comb begin
    fwd_tag_vld_o   = 1'b0;
    fwd_tag_o       = '0;
    fwd_state_vld_o = 1'b0;
    fwd_state_o     = '0;
    fwd_idx_c       = '0;
    if (wr_en_q && (wr_req_q.set == chk_set_i) && (wr_req_q.way == chk_way_i)) begin
      if ((wr_req_q.mask & L2_WR_MASK_TAG) != '0) begin
        fwd_tag_vld_o = 1'b1;
        fwd_tag_o     = wr_req_q.tag;
      end
      if ((wr_req_q.mask & L2_WR_MASK_STATE) != '0) begin
        fwd_state_vld_o = 1'b1;
        fwd_state_o     = wr_req_q.state;
      end
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      fwd_idx_c = head_ptr_c + PTR_BITS'(k);
      if (valid_c[fwd_idx_c] && (entries_c[fwd_idx_c].set == chk_set_i) &&
          (entries_c[fwd_idx_c].way == chk_way_i)) begin
        if ((entries_c[fwd_idx_c].mask & L2_WR_MASK_TAG) != '0) begin
          fwd_tag_vld_o = 1'b1;
          fwd_tag_o     = entries_c[fwd_idx_c].tag;
        end
        if ((entries_c[fwd_idx_c].mask & L2_WR_MASK_STATE) != '0) begin
          fwd_state_vld_o = 1'b1;
          fwd_state_o     = entries_c[fwd_idx_c].state;
        end
      end
    end
  end
`else
  // Without forwarding only the set field of queued entries is inspected.
  logic unused_fields;
  assign unused_fields = ^{head_ptr_c, entries_c};
`endif

  assign upd_ready_o   = ~full_c;
  assign wr_en_o       = wr_en_q;
  assign wr_set_o      = wr_req_q.set;
  assign wr_way_o      = wr_req_q.way;
  assign wr_tag_o      = wr_req_q.tag;
  assign wr_state_o    = wr_req_q.state;
  assign wr_mask_o     = wr_req_q.mask;
  assign pending_cnt_o = count_c;
  assign drained_o     = empty_c & ~wr_en_q;

endmodule
